seq_det_prog: RTL

Runtime-programmable serial bit-pattern detector. It is the parametrised successor of the team's fixed-pattern sequence-detector FSMs. It accepts one qualified bit per cycle and compares the most recent cfg_len bits against a loaded pattern. It supports overlapping and non-overlapping modes, a registered one-cycle match pulse, and a saturating match counter. It sits between a serial receiver and status/interrupt logic.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_det_prog_if.sv | 36 +++
 rtl/seq_det_hist.sv | 47 ++++
 rtl/seq_det_prog.sv | 117 +++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types, defaults and width helper for the programmable sequence detector
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Length field must be able to hold the value MAX_LEN itself.
    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_prog_if.sv
// rtl/seq_det_prog_if.sv - config/data/status bundle for seq_det_prog (cfg_mask present with SEQ_DET_MASK_EN)
interface seq_det_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    parameter int LEN_W   = 4
);
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
`ifdef SEQ_DET_MASK_EN
    logic [MAX_LEN-1:0] cfg_mask;
`endif
    logic               din_valid;
    logic               din;
    logic               dout;
    logic [CNT_W-1:0]   match_cnt;
    logic               armed;
    logic               cfg_err;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
        input  dout, match_cnt, armed, cfg_err
`ifdef SEQ_DET_MASK_EN
        , output cfg_mask
`endif
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
        output dout, match_cnt, armed, cfg_err
`ifdef SEQ_DET_MASK_EN
        , input cfg_mask
`endif
    );
endinterface

// File: rtl/seq_det_hist.sv
// rtl/seq_det_hist.sv - bit history shift register with saturating fill counter
// Ports: clk, rst; shift_en (accept din), clear (wipe history and fill),
//        restart (zero fill instead of advancing it); din;
//        hist_next / fill_next are the values that will be registered this cycle.
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = calc_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               clear,
    input  logic               restart,
    input  logic               din,
    output logic [MAX_LEN-1:0] hist_next,
    output logic [LEN_W-1:0]   fill_next
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    always_comb begin
        hist_next = hist;
        fill_next = fill;
        if (shift_en) begin
            hist_next = {hist[MAX_LEN-2:0], din};
            fill_next = (fill == FILL_MAX) ? fill : fill + 1'b1;
        end
    end

    // restart only drops the fill count: older bits stay in hist but are
    // never compared until len fresh bits have arrived again.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= hist_next;
            fill <= restart ? '0 : fill_next;
        end
    end

endmodule

// File: rtl/seq_det_prog.sv
// rtl/seq_det_prog.sv - runtime-programmable serial pattern detector (optional SEQ_DET_MASK_EN adds cfg_mask)
// Ports: clk, rst (sync, active-high); bus (slave modport):
//        cfg_load/cfg_pattern/cfg_len/cfg_overlap[/cfg_mask] config load,
//        din_valid/din serial input, dout registered match pulse,
//        match_cnt saturating match count, armed (in RUN), cfg_err (rejected load pulse).
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LEN_W   = calc_len_w(MAX_LEN)
) (
    input  logic           clk,
    input  logic           rst,
    seq_det_prog_if.slave  bus
);

    state_t             state, state_next;
    logic [MAX_LEN-1:0] pat_q;
    logic [MAX_LEN-1:0] mask_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               dout_q;
    logic               err_q;

    logic               len_ok, load_ok, load_bad, shift_en, match, restart;
    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;

    assign len_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
    assign load_ok  = bus.cfg_load && len_ok;
    assign load_bad = bus.cfg_load && !len_ok;
    // Any load, accepted or not, swallows the bit presented with it.
    assign shift_en = (state == RUN) && bus.din_valid && !bus.cfg_load;

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign match   = shift_en && (fill_next >= len_q) &&
                     (((hist_next ^ pat_q) & ~mask_q & len_mask) == '0);
    assign restart = match && !ovl_q;

    seq_det_hist #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .clear     (load_ok),
        .restart   (restart),
        .din       (bus.din),
        .hist_next (hist_next),
        .fill_next (fill_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (load_ok) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= '0;
            len_q  <= '0;
            ovl_q  <= 1'b1;
            cnt_q  <= '0;
            dout_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            dout_q <= match;
            err_q  <= load_bad;
            if (load_ok) begin
                pat_q <= bus.cfg_pattern;
                len_q <= bus.cfg_len;
                ovl_q <= bus.cfg_overlap;
                cnt_q <= '0;
            end else if (match && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef SEQ_DET_MASK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else if (load_ok) begin
            mask_q <= bus.cfg_mask;
        end
    end
`else
    assign mask_q = '0;
`endif

    assign bus.dout      = dout_q;
    assign bus.match_cnt = cnt_q;
    assign bus.armed     = (state == RUN);
    assign bus.cfg_err   = err_q;

endmodule
